// File: rtl/bp_pkg.sv
// Shared definitions for the frame update scheduler: FSM state encodings,
// VGA 640x480 timing constants and a small width helper.
package bp_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        GAP  = ST_GAP
    } sched_state_t;

    // VGA 640x480 horizontal timing, in pixel clocks
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // VGA 640x480 vertical timing, in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Sync lines idle high and pulse low
    localparam logic SYNC_IDLE_LEVEL = 1'b1;

    // Pixel clocks available for game-state updates during vertical blanking
    localparam int V_BLANK_LINES  = V_FRONT + V_SYNC + V_BACK;
    localparam int V_BLANK_CYCLES = V_BLANK_LINES * H_TOTAL;

    // Index width for n clients, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upd_watchdog.sv
// Per-slot watchdog: loaded when a client is granted, counts down while the
// grant is outstanding and flags expiry when the count reaches zero.
module upd_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic px_clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    // Loading TIMEOUT-1 lets the grant stay high for exactly TIMEOUT cycles
    localparam logic [WD_W-1:0] LOAD_VAL = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;

    // Next count: reload on a new grant, otherwise count down while enabled
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == '0);

endmodule

// File: rtl/frame_update_scheduler.sv
// Frame update scheduler: on each VSYNC falling edge grants one update slot to
// every client in index order with a req/ack handshake, a watchdog per slot,
// a frame counter and sticky overrun / timeout flags.
module frame_update_scheduler
    import bp_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                   px_clk,
    input  logic                   rst,
    input  logic                   vsync_i,
    input  logic                   enable_i,
    input  logic [NUM_CLIENTS-1:0] upd_ack_i,
    input  logic                   clr_err_i,
    output logic [NUM_CLIENTS-1:0] upd_req_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       frame_cnt_o,
    output logic                   overrun_o,
    output logic [NUM_CLIENTS-1:0] to_err_o
);

    localparam int IDX_W = idx_width(NUM_CLIENTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

    sched_state_t           state_q,    state_d;
    logic [IDX_W-1:0]       slotIdx_q,  slotIdx_d;
    logic [NUM_CLIENTS-1:0] updReq_q,   updReq_d;
    logic                   busy_q,     busy_d;
    logic [CNT_W-1:0]       frameCnt_q, frameCnt_d;
    logic                   overrun_q,  overrun_d;
    logic [NUM_CLIENTS-1:0] toErr_q,    toErr_d;
    logic                   vsDly_q;

    logic vsyncFall;
    logic slotAck;
    logic wdLoad;
    logic wdEn;
    logic wdExpired;

    // One-hot grant vector for a slot index
    function automatic logic [NUM_CLIENTS-1:0] slotGrant(input logic [IDX_W-1:0] idx);
        logic [NUM_CLIENTS-1:0] grant;
        grant      = '0;
        grant[idx] = 1'b1;
        return grant;
    endfunction

    assign vsyncFall = vsDly_q & ~vsync_i;
    assign slotAck   = upd_ack_i[slotIdx_q];
    assign wdEn      = (state_q == REQ);

    upd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .px_clk  (px_clk),
        .rst     (rst),
        .load    (wdLoad),
        .en      (wdEn),
        .expired (wdExpired)
    );

    // Next-state logic: slot sequencing, frame counting and sticky error flags
    always_comb begin
        state_d    = state_q;
        slotIdx_d  = slotIdx_q;
        updReq_d   = updReq_q;
        busy_d     = busy_q;
        frameCnt_d = frameCnt_q;
        overrun_d  = clr_err_i ? 1'b0 : overrun_q;
        toErr_d    = clr_err_i ? '0 : toErr_q;
        wdLoad     = 1'b0;

        // Every falling edge is counted; one that lands mid-sequence is an overrun
        if (vsyncFall) begin
            frameCnt_d = frameCnt_q + 1'b1;
            if (state_q != IDLE) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (vsyncFall && enable_i) begin
                    state_d   = REQ;
                    slotIdx_d = '0;
                    updReq_d  = slotGrant('0);
                    busy_d    = 1'b1;
                    wdLoad    = 1'b1;
                end
            end
            REQ: begin
                // An ack in the expiry cycle still counts as a clean completion
                if (slotAck) begin
                    updReq_d = '0;
                    state_d  = GAP;
                end else if (wdExpired) begin
                    toErr_d[slotIdx_q] = 1'b1;
                    updReq_d           = '0;
                    state_d            = GAP;
                end
            end
            GAP: begin
                if (slotIdx_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    slotIdx_d = slotIdx_q + 1'b1;
                    updReq_d  = slotGrant(slotIdx_q + 1'b1);
                    wdLoad    = 1'b1;
                    state_d   = REQ;
                end
            end
            default: begin
                state_d  = IDLE;
                updReq_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            slotIdx_q  <= '0;
            updReq_q   <= '0;
            busy_q     <= 1'b0;
            frameCnt_q <= '0;
            overrun_q  <= 1'b0;
            toErr_q    <= '0;
            vsDly_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            slotIdx_q  <= slotIdx_d;
            updReq_q   <= updReq_d;
            busy_q     <= busy_d;
            frameCnt_q <= frameCnt_d;
            overrun_q  <= overrun_d;
            toErr_q    <= toErr_d;
            vsDly_q    <= vsync_i;
        end
    end

    assign upd_req_o   = updReq_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frameCnt_q;
    assign overrun_o   = overrun_q;
    assign to_err_o    = toErr_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Testbench for frame_update_scheduler: behavioural clients with programmable
// ack delays, a run-length monitor of grants and busy, and a frame-level
// reference model (grant order, per-slot hold time, sticky flags).
module tb_frame_update_scheduler;

    localparam int NUM     = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 16;
    localparam int HALF    = 5;
    localparam int NEVER   = 1000;

    logic             px_clk = 1'b0;
    logic             rst;
    logic             vsync;
    logic             enable;
    logic [NUM-1:0]   updAck;
    logic             clrErr;
    logic [NUM-1:0]   updReq;
    logic             busy;
    logic [CNT_W-1:0] frameCnt;
    logic             overrun;
    logic [NUM-1:0]   toErr;

    int compared   = 0;
    int mismatched = 0;

    int ackDelay[NUM];
    int held[NUM];
    bit ackNoise;

    int grantIdx[$];
    int grantLen[$];
    int busyLen[$];

    int             expFrames;
    logic [NUM-1:0] expToErr;
    logic           expOverrun;

    always #HALF px_clk = ~px_clk;

    frame_update_scheduler #(
        .NUM_CLIENTS (NUM),
        .TIMEOUT     (TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .px_clk      (px_clk),
        .rst         (rst),
        .vsync_i     (vsync),
        .enable_i    (enable),
        .upd_ack_i   (updAck),
        .clr_err_i   (clrErr),
        .upd_req_o   (updReq),
        .busy_o      (busy),
        .frame_cnt_o (frameCnt),
        .overrun_o   (overrun),
        .to_err_o    (toErr)
    );

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Monitor: record each grant as (client, cycles high) and each busy run length
    logic [NUM-1:0] prevReq;
    logic           prevBusy;
    int             reqRun;
    int             busyRun;
    always @(negedge px_clk) begin
        if (rst) begin
            prevReq  = '0;
            prevBusy = 1'b0;
            reqRun   = 0;
            busyRun  = 0;
        end else begin
            checkOutput("req one-hot", longint'($countones(updReq) <= 1), 1);
            if (updReq != prevReq) begin
                if (prevReq != '0) begin
                    grantIdx.push_back($clog2(prevReq));
                    grantLen.push_back(reqRun);
                end
                reqRun = 1;
            end else begin
                reqRun++;
            end
            if (busy && !prevBusy) busyRun = 1;
            else if (busy) busyRun++;
            else if (prevBusy) busyLen.push_back(busyRun);
            prevReq  = updReq;
            prevBusy = busy;
        end
    end

    // Advance one cycle; clients answer their grants after their programmed delay
    task automatic tick();
        @(posedge px_clk);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (updReq[i]) begin
                held[i]++;
                updAck[i] = (held[i] > ackDelay[i]);
            end else begin
                held[i]   = 0;
                updAck[i] = ackNoise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    endtask

    // One-cycle low VSYNC pulse; the fall is seen at the next clock edge
    task automatic applyStimulus();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        expFrames++;
    endtask

    task automatic setDelays(input int d0, input int d1, input int d2, input int d3);
        ackDelay[0] = d0;
        ackDelay[1] = d1;
        ackDelay[2] = d2;
        ackDelay[3] = d3;
    endtask

    task automatic clearLog();
        grantIdx.delete();
        grantLen.delete();
        busyLen.delete();
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) @(posedge px_clk);
        #1;
        rst = 1'b0;
        expFrames  = 0;
        expToErr   = '0;
        expOverrun = 1'b0;
        for (int i = 0; i < NUM; i++) held[i] = 0;
        clearLog();
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checkOutput({tag, " idle in time"}, busy, 0);
        repeat (2) tick();
    endtask

    task automatic waitReq(input int c, input string tag);
        int n = 0;
        while (!updReq[c] && n < 100) begin
            tick();
            n++;
        end
        checkOutput({tag, " req seen"}, updReq[c], 1);
    endtask

    task automatic clearErrors();
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        expToErr   = '0;
        expOverrun = 1'b0;
        checkOutput("clr overrun", overrun, 0);
        checkOutput("clr to_err", toErr, 0);
    endtask

    // Compare the logged frame with the model: clients in order, each held
    // min(delay+1, TIMEOUT) cycles plus one gap cycle, error iff delay >= TIMEOUT
    task automatic checkFrame(input string tag, input bit expectRun);
        int expBusy = 0;
        if (expectRun) begin
            checkOutput({tag, " grant count"}, grantIdx.size(), NUM);
            for (int i = 0; i < NUM && i < grantIdx.size(); i++) begin
                int dur = (ackDelay[i] + 1 < TIMEOUT) ? ackDelay[i] + 1 : TIMEOUT;
                checkOutput($sformatf("%s grant%0d client", tag, i), grantIdx[i], i);
                checkOutput($sformatf("%s grant%0d length", tag, i), grantLen[i], dur);
                expBusy += dur + 1;
                if (ackDelay[i] >= TIMEOUT) expToErr[i] = 1'b1;
            end
            checkOutput({tag, " busy runs"}, busyLen.size(), 1);
            checkOutput({tag, " busy length"}, (busyLen.size() > 0) ? busyLen[0] : -1, expBusy);
        end else begin
            checkOutput({tag, " no grants"}, grantIdx.size(), 0);
            checkOutput({tag, " no busy"}, busyLen.size(), 0);
        end
        checkOutput({tag, " frame_cnt"}, frameCnt, expFrames);
        checkOutput({tag, " to_err"}, toErr, expToErr);
        checkOutput({tag, " overrun"}, overrun, expOverrun);
        clearLog();
    endtask

    initial begin
        rst      = 1'b1;
        vsync    = 1'b1;
        enable   = 1'b1;
        updAck   = '0;
        clrErr   = 1'b0;
        ackNoise = 1'b0;
        setDelays(1, 1, 1, 1);
        doReset();

        $display("[TB] reset state");
        checkOutput("reset upd_req", updReq, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset frame_cnt", frameCnt, 0);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset to_err", toErr, 0);

        $display("[TB] every client acks one cycle after its req");
        applyStimulus();
        waitIdle("t1");
        checkFrame("t1", 1'b1);

        $display("[TB] client 2 never acks");
        ackNoise = 1'b1;
        setDelays($urandom_range(0, 3), $urandom_range(0, 3), NEVER, $urandom_range(0, 3));
        applyStimulus();
        waitIdle("t2");
        checkFrame("t2", 1'b1);
        checkOutput("t2 to_err mask", toErr, 4'b0100);

        $display("[TB] VSYNC falls during client 1 request");
        setDelays(0, 5, 2, 1);
        applyStimulus();
        waitReq(1, "t3");
        applyStimulus();
        expOverrun = 1'b1;
        waitIdle("t3");
        checkFrame("t3", 1'b1);
        repeat (5) tick();
        checkOutput("t3 no restart grants", grantIdx.size(), 0);
        checkOutput("t3 no restart busy", busy, 0);

        $display("[TB] ack in expiry cycle, then clr_err against overrun set");
        clearErrors();
        setDelays(TIMEOUT - 1, 0, TIMEOUT - 1, 2);
        applyStimulus();
        waitIdle("t4a");
        checkFrame("t4a", 1'b1);
        setDelays(3, 3, 3, 3);
        applyStimulus();
        repeat (3) tick();
        vsync  = 1'b0;
        clrErr = 1'b1;
        tick();
        vsync  = 1'b1;
        clrErr = 1'b0;
        expFrames++;
        expOverrun = 1'b1;
        checkOutput("t4b overrun set beats clr", overrun, 1);
        waitIdle("t4b");
        checkFrame("t4b", 1'b1);

        $display("[TB] asynchronous reset during client 1 request");
        setDelays(0, 6, 0, 0);
        applyStimulus();
        waitReq(1, "t5");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5 async upd_req", updReq, 0);
        checkOutput("t5 async busy", busy, 0);
        checkOutput("t5 async frame_cnt", frameCnt, 0);
        tick();
        tick();
        rst = 1'b0;
        expFrames  = 0;
        expToErr   = '0;
        expOverrun = 1'b0;
        clearLog();
        setDelays($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
        applyStimulus();
        waitIdle("t5");
        checkFrame("t5", 1'b1);

        $display("[TB] enable low across three frames, then dropped mid-sequence");
        doReset();
        enable = 1'b0;
        repeat (3) begin
            applyStimulus();
            repeat (4) tick();
        end
        checkFrame("t6 disabled", 1'b0);
        enable = 1'b1;
        setDelays(2, 2, 2, 2);
        applyStimulus();
        enable = 1'b0;
        waitIdle("t6");
        checkFrame("t6 drop", 1'b1);

        $display("[TB] randomized frames");
        clearErrors();
        for (int k = 0; k < 20; k++) begin
            bit en;
            en       = ($urandom_range(0, 3) != 0);
            enable   = en;
            ackNoise = 1'($urandom_range(0, 1));
            setDelays($urandom_range(0, 10), $urandom_range(0, 10),
                      $urandom_range(0, 10), $urandom_range(0, 10));
            repeat ($urandom_range(1, 5)) tick();
            applyStimulus();
            if ($urandom_range(0, 1) == 1) enable = ~enable;
            waitIdle($sformatf("rnd%0d", k));
            checkFrame($sformatf("rnd%0d", k), en);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
